usb_ep_status_bridge: RTL and testbench

Control-side bridge between the SoC register bus and the aux R/W port of the endpoint status store. It turns single bus requests into correctly handshaked aux-port accesses and absorbs the three-cycle aux read latency. It adds atomic set-bits/clear-bits read-modify-write operations so firmware can update EP status words without a software read/write pair. It sits directly upstream of the EP status store's aux port; the priority port belongs to the USB transaction engine and is not touched here.

---
 rtl/usb_ep_status_bridge.sv | 166 ++++++++++++++++
 tb/tb_usb_ep_status_bridge.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_status_bridge.sv
// ---------------------------------------------------------------------------
// usb_ep_status_bridge
//
// Purpose:
//   Control-side bridge between the SoC register bus and the aux R/W port of
//   the endpoint status store. A single bus request becomes a handshaked aux
//   access. The bridge absorbs the fixed three-cycle aux read latency. It also
//   provides atomic set-bits / clear-bits read-modify-write operations.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   bus_req    request strobe, sampled only in IDLE
//   bus_op     00 read, 01 write, 10 set-bits, 11 clear-bits
//   bus_addr   EP status word address (9 bits)
//   bus_din    write data / bit mask (16 bits)
//   bus_ack    one-cycle completion pulse
//   bus_dout   pre-modification word for read / set / clear
//   bus_busy   high whenever the bridge is not idle
//   s_addr_0   aux address
//   s_read_0   aux read request
//   s_zero_0   aux zero-read request (never used, tied low)
//   s_write_0  aux write request
//   s_din_0    aux write data
//   s_ready_0  aux accepted this cycle
//   s_dout_3   aux read data, valid three cycles after acceptance
// ---------------------------------------------------------------------------
module usb_ep_status_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic [1:0]  bus_op,
  input  logic [8:0]  bus_addr,
  input  logic [15:0] bus_din,
  output logic        bus_ack,
  output logic [15:0] bus_dout,
  output logic        bus_busy,
  output logic [8:0]  s_addr_0,
  output logic        s_read_0,
  output logic        s_zero_0,
  output logic        s_write_0,
  output logic [15:0] s_din_0,
  input  logic        s_ready_0,
  input  logic [15:0] s_dout_3
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t      state_r;
  logic [1:0]  op_r;
  logic [15:0] din_r;
  // Counts down the remaining RD_WAIT cycles; zero marks the data-valid cycle.
  logic [1:0]  cnt_r;

  // New word for a read-modify-write given the old value and the bus mask.
  function automatic logic [15:0] rmw_merge(input logic [1:0]  op,
                                            input logic [15:0] old_word,
                                            input logic [15:0] mask);
    logic [15:0] res;
    case (op)
      OP_SET:   res = old_word | mask;
      OP_CLEAR: res = old_word & ~mask;
      default:  res = old_word;
    endcase
    return res;
  endfunction

  // The zero-read feature of the store is not used by this bridge.
  assign s_zero_0 = 1'b0;

  // Bridge FSM; every output is registered and updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= 2'b00;
      din_r     <= 16'h0000;
      cnt_r     <= 2'd0;
      bus_ack   <= 1'b0;
      bus_dout  <= 16'h0000;
      bus_busy  <= 1'b0;
      s_addr_0  <= 9'h000;
      s_read_0  <= 1'b0;
      s_write_0 <= 1'b0;
      s_din_0   <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus_req) begin
            op_r     <= bus_op;
            din_r    <= bus_din;
            s_addr_0 <= bus_addr;
            bus_busy <= 1'b1;
            if (bus_op == OP_WRITE) begin
              s_din_0   <= bus_din;
              s_write_0 <= 1'b1;
              state_r   <= WR_ISSUE;
            end else begin
              s_read_0 <= 1'b1;
              state_r  <= RD_ISSUE;
            end
          end
        end

        RD_ISSUE: begin
          // Acceptance cycle: drop the request and start the latency count.
          if (s_ready_0) begin
            s_read_0 <= 1'b0;
            cnt_r    <= 2'd2;
            state_r  <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // s_dout_3 is only trusted in the cycle where the count hits zero.
          if (cnt_r == 2'd0) begin
            bus_dout <= s_dout_3;
            if (op_r == OP_READ) begin
              bus_ack <= 1'b1;
              state_r <= DONE;
            end else begin
              s_din_0   <= rmw_merge(op_r, s_dout_3, din_r);
              s_write_0 <= 1'b1;
              state_r   <= WR_ISSUE;
            end
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end

        WR_ISSUE: begin
          if (s_ready_0) begin
            s_write_0 <= 1'b0;
            bus_ack   <= 1'b1;
            state_r   <= DONE;
          end
        end

        DONE: begin
          bus_ack  <= 1'b0;
          bus_busy <= 1'b0;
          state_r  <= IDLE;
        end

        default: begin
          bus_ack   <= 1'b0;
          bus_busy  <= 1'b0;
          s_read_0  <= 1'b0;
          s_write_0 <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_ep_status_bridge.sv
// ---------------------------------------------------------------------------
// tb_usb_ep_status_bridge
//
// Bench for usb_ep_status_bridge. Contains a small behavioural model of the
// EP status store aux port (memory, 3-cycle read pipeline, garbage outside
// the valid cycle), a table of directed transactions and hand-written
// sequences for stalls, back-to-back requests and resets mid-access.
// ---------------------------------------------------------------------------
module tb_usb_ep_status_bridge;

  logic        clk;
  logic        rst;
  logic        bus_req;
  logic [1:0]  bus_op;
  logic [8:0]  bus_addr;
  logic [15:0] bus_din;
  logic        bus_ack;
  logic [15:0] bus_dout;
  logic        bus_busy;
  logic [8:0]  s_addr_0;
  logic        s_read_0;
  logic        s_zero_0;
  logic        s_write_0;
  logic [15:0] s_din_0;
  logic        s_ready_0;
  logic [15:0] s_dout_3;

  usb_ep_status_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_op    (bus_op),
    .bus_addr  (bus_addr),
    .bus_din   (bus_din),
    .bus_ack   (bus_ack),
    .bus_dout  (bus_dout),
    .bus_busy  (bus_busy),
    .s_addr_0  (s_addr_0),
    .s_read_0  (s_read_0),
    .s_zero_0  (s_zero_0),
    .s_write_0 (s_write_0),
    .s_din_0   (s_din_0),
    .s_ready_0 (s_ready_0),
    .s_dout_3  (s_dout_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- store model ----------------
  logic [15:0] mem [0:511];
  logic        preload_done_r = 1'b0;
  logic        p1_v = 1'b0, p2_v = 1'b0, p3_v = 1'b0;
  logic [8:0]  p1_a = 9'h0, p2_a = 9'h0, p3_a = 9'h0;
  logic [15:0] garbage_r = 16'hDEAD;
  int          rd_acc = 0, wr_acc = 0, ack_cnt = 0, both_cnt = 0;

  assign s_dout_3 = p3_v ? mem[p3_a] : garbage_r;

  always @(posedge clk) begin
    if (!preload_done_r) begin
      for (int i = 0; i < 512; i++) mem[i] <= 16'h0000;
      mem[9'h005] <= 16'hBEEF;
      mem[9'h010] <= 16'h8001;
      mem[9'h020] <= 16'hFFFF;
      preload_done_r <= 1'b1;
    end else if (s_write_0 && s_ready_0) begin
      mem[s_addr_0] <= s_din_0;
    end
    p1_v <= s_read_0 && s_ready_0;
    p1_a <= s_addr_0;
    p2_v <= p1_v;  p2_a <= p1_a;
    p3_v <= p2_v;  p3_a <= p2_a;
    garbage_r <= garbage_r + 16'h0101;
    if (s_read_0 && s_ready_0)  rd_acc   <= rd_acc + 1;
    if (s_write_0 && s_ready_0) wr_acc   <= wr_acc + 1;
    if (s_read_0 && s_write_0)  both_cnt <= both_cnt + 1;
    if (bus_ack)                ack_cnt  <= ack_cnt + 1;
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction starting at a negedge; s_ready_0 is low for the first
  // 'stall' cycles after the request cycle. Returns cycles from req to ack.
  task automatic run_txn(input logic [1:0] op, input logic [8:0] addr,
                         input logic [15:0] din, input int stall,
                         output int lat, output logic timed_out);
    bus_op = op; bus_addr = addr; bus_din = din; bus_req = 1'b1;
    s_ready_0 = 1'b0;
    lat = 0;
    timed_out = 1'b0;
    @(negedge clk);
    bus_req = 1'b0;
    lat = 1;
    s_ready_0 = (lat > stall);
    while (!bus_ack && lat < 40) begin
      @(negedge clk);
      lat++;
      s_ready_0 = (lat > stall);
    end
    if (!bus_ack) timed_out = 1'b1;
    s_ready_0 = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ack"},   {31'h0, bus_ack},   32'h0);
    chk({tag, "_busy"},  {31'h0, bus_busy},  32'h0);
    chk({tag, "_dout"},  {16'h0, bus_dout},  32'h0);
    chk({tag, "_rd"},    {31'h0, s_read_0},  32'h0);
    chk({tag, "_wr"},    {31'h0, s_write_0}, 32'h0);
    chk({tag, "_zero"},  {31'h0, s_zero_0},  32'h0);
    chk({tag, "_addr"},  {23'h0, s_addr_0},  32'h0);
    chk({tag, "_sdin"},  {16'h0, s_din_0},   32'h0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [8:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic [15:0] exp_mem;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t        vecs [8];
  logic [1:0]  c_op   [6];
  logic [15:0] c_din  [6];
  logic [15:0] c_dout [6];

  initial begin
    int lat;
    logic to;
    int rd0, wr0, ack0;

    vecs[0] = '{2'b00, 9'h005, 16'h0000, 16'hBEEF, 16'hBEEF, 5, 1, 0};
    vecs[1] = '{2'b01, 9'h1FF, 16'h4321, 16'hBEEF, 16'h4321, 2, 0, 1};
    vecs[2] = '{2'b10, 9'h010, 16'h00F0, 16'h8001, 16'h80F1, 6, 1, 1};
    vecs[3] = '{2'b11, 9'h010, 16'h8000, 16'h80F1, 16'h00F1, 6, 1, 1};
    vecs[4] = '{2'b00, 9'h1FF, 16'hFFFF, 16'h4321, 16'h4321, 5, 1, 0};
    vecs[5] = '{2'b11, 9'h020, 16'h0F0F, 16'hFFFF, 16'hF0F0, 6, 1, 1};
    vecs[6] = '{2'b10, 9'h000, 16'hA5A5, 16'h0000, 16'hA5A5, 6, 1, 1};
    vecs[7] = '{2'b01, 9'h005, 16'h0000, 16'h0000, 16'h0000, 2, 0, 1};

    c_op[0] = 2'b01; c_din[0] = 16'h1111; c_dout[0] = 16'h0000;
    c_op[1] = 2'b00; c_din[1] = 16'h0000; c_dout[1] = 16'h1111;
    c_op[2] = 2'b01; c_din[2] = 16'h2222; c_dout[2] = 16'h0000;
    c_op[3] = 2'b00; c_din[3] = 16'h0000; c_dout[3] = 16'h2222;
    c_op[4] = 2'b10; c_din[4] = 16'h000F; c_dout[4] = 16'h2222;
    c_op[5] = 2'b00; c_din[5] = 16'h0000; c_dout[5] = 16'h222F;

    rst = 1'b1; bus_req = 1'b0; bus_op = 2'b00; bus_addr = 9'h0;
    bus_din = 16'h0; s_ready_0 = 1'b1;
    @(negedge clk); @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // ---------------- table of directed transactions ----------------
    for (int v = 0; v < 8; v++) begin
      rd0 = rd_acc; wr0 = wr_acc;
      run_txn(vecs[v].op, vecs[v].addr, vecs[v].din, 0, lat, to);
      chk($sformatf("v%0d_timeout", v), {31'h0, to}, 32'h0);
      chk($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
      chk($sformatf("v%0d_dout", v), {16'h0, bus_dout}, {16'h0, vecs[v].exp_dout});
      @(negedge clk);
      chk($sformatf("v%0d_ack_pulse", v), {31'h0, bus_ack}, 32'h0);
      chk($sformatf("v%0d_idle", v), {31'h0, bus_busy}, 32'h0);
      chk($sformatf("v%0d_mem", v), {16'h0, mem[vecs[v].addr]}, {16'h0, vecs[v].exp_mem});
      chk($sformatf("v%0d_rdcnt", v), rd_acc - rd0, vecs[v].exp_rd);
      chk($sformatf("v%0d_wrcnt", v), wr_acc - wr0, vecs[v].exp_wr);
    end

    // ---------------- write with ready low in cycles 1-3 ----------------
    wr0 = wr_acc;
    bus_op = 2'b01; bus_addr = 9'h1FF; bus_din = 16'h1234; bus_req = 1'b1;
    s_ready_0 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus_req = 1'b0;
      chk($sformatf("wstall_c%0d_wr", k), {31'h0, s_write_0}, 32'h1);
      chk($sformatf("wstall_c%0d_rd", k), {31'h0, s_read_0}, 32'h0);
      chk($sformatf("wstall_c%0d_addr", k), {23'h0, s_addr_0}, 32'h1FF);
      chk($sformatf("wstall_c%0d_din", k), {16'h0, s_din_0}, 32'h1234);
      chk($sformatf("wstall_c%0d_ack", k), {31'h0, bus_ack}, 32'h0);
      s_ready_0 = (k == 4);
    end
    @(negedge clk);
    chk("wstall_ack_c5", {31'h0, bus_ack}, 32'h1);
    chk("wstall_wr_drop", {31'h0, s_write_0}, 32'h0);
    chk("wstall_dout_kept", {16'h0, bus_dout}, 32'h0000);
    s_ready_0 = 1'b1;
    @(negedge clk);
    chk("wstall_single", wr_acc - wr0, 1);
    chk("wstall_mem", {16'h0, mem[9'h1FF]}, 32'h1234);

    // ---------------- read with 2 stall cycles; garbage rejected ----------------
    run_txn(2'b00, 9'h010, 16'h0000, 2, lat, to);
    chk("rstall_timeout", {31'h0, to}, 32'h0);
    chk("rstall_lat", lat, 7);
    chk("rstall_dout", {16'h0, bus_dout}, 32'h00F1);
    @(negedge clk);

    // ---------------- bus_req held high, alternating ops ----------------
    rd0 = rd_acc; wr0 = wr_acc; ack0 = ack_cnt;
    bus_addr = 9'h030;
    bus_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int n;
      bus_op = c_op[i];
      bus_din = c_din[i];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus_ack && n < 40);
      chk($sformatf("b2b_op%0d_acked", i), {31'h0, bus_ack}, 32'h1);
      if (c_op[i] != 2'b01)
        chk($sformatf("b2b_op%0d_dout", i), {16'h0, bus_dout}, {16'h0, c_dout[i]});
    end
    bus_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_acks", ack_cnt - ack0, 6);
    chk("b2b_reads", rd_acc - rd0, 4);
    chk("b2b_writes", wr_acc - wr0, 3);
    chk("b2b_mem", {16'h0, mem[9'h030]}, 32'h222F);

    // ---------------- reset during RD_WAIT ----------------
    ack0 = ack_cnt;
    bus_op = 2'b00; bus_addr = 9'h1FF; bus_din = 16'h0; bus_req = 1'b1;
    @(negedge clk);
    bus_req = 1'b0;
    chk("rst_rd_issued", {31'h0, s_read_0}, 32'h1);
    @(negedge clk);
    chk("rst_rd_inwait", {31'h0, bus_busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("rst_rdwait");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_rd_noack", ack_cnt - ack0, 0);
    chk("rst_rd_nocapture", {16'h0, bus_dout}, 32'h0);
    run_txn(2'b00, 9'h1FF, 16'h0000, 0, lat, to);
    chk("rst_rd_next_lat", lat, 5);
    chk("rst_rd_next_dout", {16'h0, bus_dout}, 32'h1234);
    @(negedge clk);

    // ---------------- reset during WR_ISSUE ----------------
    ack0 = ack_cnt; wr0 = wr_acc;
    bus_op = 2'b01; bus_addr = 9'h0AA; bus_din = 16'h5555; bus_req = 1'b1;
    s_ready_0 = 1'b0;
    @(negedge clk);
    bus_req = 1'b0;
    @(negedge clk);
    chk("rst_wr_inissue", {31'h0, s_write_0}, 32'h1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("rst_wrissue");
    @(negedge clk);
    rst = 1'b0;
    s_ready_0 = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_wr_noack", ack_cnt - ack0, 0);
    chk("rst_wr_nowrite", wr_acc - wr0, 0);
    chk("rst_wr_mem_untouched", {16'h0, mem[9'h0AA]}, 32'h0);
    run_txn(2'b01, 9'h0AA, 16'h5555, 0, lat, to);
    chk("rst_wr_next_lat", lat, 2);
    @(negedge clk);
    chk("rst_wr_next_mem", {16'h0, mem[9'h0AA]}, 32'h5555);

    chk("never_rd_and_wr", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
